// File: rtl/acc_job_arbiter.sv
// Round-robin arbiter that shares one accumulate datapath between N_REQ requesters.
// A RUN-state watchdog aborts any job whose datapath never reports done.
module acc_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len_flat,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   err,
    output logic                   busy,
    output logic                   dp_load,
    output logic [CNT_W-1:0]       dp_len,
    output logic                   dp_clr,
    input  logic                   dp_done
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] win_reg;
    logic [CNT_W-1:0] len_reg;
    logic [WD_W-1:0]  wdog_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [N_REQ-1:0] ack_reg;
    logic             err_reg;
    logic             busy_reg;
    logic             dp_load_reg;
    logic [CNT_W-1:0] dp_len_reg;
    logic             dp_clr_reg;

    logic [CNT_W-1:0] len_arr [N_REQ];
    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_req;
    logic [IDX_W-1:0] arb_idx_next;
    logic [IDX_W-1:0] rr_ptr_next;

    // Candidate gi is the requester gi places after the round-robin pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            logic [IDX_W:0] sum;
            assign len_arr[gi]  = len_flat[gi*CNT_W +: CNT_W];
            assign sum          = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ))
                                  ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                  : sum[IDX_W-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest requesting candidate wins.
    always_comb begin
        arb_idx_next = cand_idx[0];
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                arb_idx_next = cand_idx[k];
            end
        end
    end

    assign rr_ptr_next = (win_reg == IDX_W'(N_REQ - 1)) ? '0 : win_reg + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            win_reg     <= '0;
            len_reg     <= '0;
            wdog_reg    <= '0;
            gnt_reg     <= '0;
            ack_reg     <= '0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            dp_load_reg <= 1'b0;
            dp_len_reg  <= '0;
            dp_clr_reg  <= 1'b0;
        end else begin
            ack_reg     <= '0;
            err_reg     <= 1'b0;
            dp_load_reg <= 1'b0;
            dp_clr_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg <= GRANT;
                        win_reg   <= arb_idx_next;
                        len_reg   <= len_arr[arb_idx_next];
                        gnt_reg   <= N_REQ'(1) << arb_idx_next;
                        busy_reg  <= 1'b1;
                    end
                end
                GRANT: begin
                    // Zero-length jobs complete without touching the datapath.
                    if (len_reg == '0) begin
                        state_reg <= DONE;
                        ack_reg   <= gnt_reg;
                    end else begin
                        state_reg   <= LOAD;
                        dp_load_reg <= 1'b1;
                        dp_len_reg  <= len_reg;
                        wdog_reg    <= '0;
                    end
                end
                LOAD: begin
                    state_reg <= RUN;
                    wdog_reg  <= '0;
                end
                RUN: begin
                    if (dp_done) begin
                        state_reg  <= DONE;
                        ack_reg    <= gnt_reg;
                        dp_clr_reg <= 1'b1;
                    end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
                        state_reg  <= DONE;
                        ack_reg    <= gnt_reg;
                        err_reg    <= 1'b1;
                        dp_clr_reg <= 1'b1;
                    end else begin
                        wdog_reg <= wdog_reg + WD_W'(1);
                    end
                end
                DONE: begin
                    state_reg  <= IDLE;
                    gnt_reg    <= '0;
                    busy_reg   <= 1'b0;
                    rr_ptr_reg <= rr_ptr_next;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign ack     = ack_reg;
    assign err     = err_reg;
    assign busy    = busy_reg;
    assign dp_load = dp_load_reg;
    assign dp_len  = dp_len_reg;
    assign dp_clr  = dp_clr_reg;

endmodule

// File: tb/tb_acc_job_arbiter.sv
// Bench for acc_job_arbiter: job-timeline model checked every cycle, plus directed
// scenarios with hand-computed latencies; a second instance exercises an 8-cycle watchdog.
module tb_acc_job_arbiter;
    localparam int N_REQ    = 4;
    localparam int CNT_W    = 5;
    localparam int TO_MAIN  = 64;
    localparam int TO_SHORT = 8;
    localparam int VW       = 2*N_REQ + 4 + CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] len_flat;
    logic [N_REQ-1:0]       gnt, ack;
    logic                   err, busy, dp_load, dp_clr, dp_done;
    logic [CNT_W-1:0]       dp_len;

    logic [N_REQ-1:0]       req_to;
    logic [N_REQ*CNT_W-1:0] len_to;
    logic [N_REQ-1:0]       gnt_to, ack_to;
    logic                   err_to, busy_to, dp_load_to, dp_clr_to, dp_done_to;
    logic [CNT_W-1:0]       dp_len_to;

    acc_job_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W), .TIMEOUT(TO_MAIN)) u_dut (
        .clk(clk), .rst(rst), .req(req), .len_flat(len_flat),
        .gnt(gnt), .ack(ack), .err(err), .busy(busy),
        .dp_load(dp_load), .dp_len(dp_len), .dp_clr(dp_clr), .dp_done(dp_done)
    );

    acc_job_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W), .TIMEOUT(TO_SHORT)) u_dut_to (
        .clk(clk), .rst(rst), .req(req_to), .len_flat(len_to),
        .gnt(gnt_to), .ack(ack_to), .err(err_to), .busy(busy_to),
        .dp_load(dp_load_to), .dp_len(dp_len_to), .dp_clr(dp_clr_to), .dp_done(dp_done_to)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len_flat[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ack == '0 && n < limit);
        chk("ack_seen", 32'(ack != '0), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < limit);
        chk("idle_seen", 32'(busy), 32'd0);
    endtask

    function automatic int oh2idx(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Datapath stand-in: raises dp_done dp_delay cycles after a load, drops it on dp_clr.
    int   dp_delay = 4;
    logic dp_tie0  = 1'b0;
    int   dp_cnt;
    initial begin
        dp_done = 1'b0;
        dp_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || dp_clr) begin
                dp_done = 1'b0;
                dp_cnt  = 0;
            end else if (dp_load) begin
                dp_cnt = dp_delay;
            end else if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0 && !dp_tie0) dp_done = 1'b1;
            end
        end
    end

    // Job-timeline model: a job granted at edge s shows gnt after s, loads after s+1,
    // runs from edge s+3, and ends at the edge that sees dp_done or exhausts the watchdog.
    logic                   p_rst = 1'b1;
    logic [N_REQ-1:0]       p_req = '0;
    logic [N_REQ*CNT_W-1:0] p_len = '0;
    logic                   p_done = 1'b0;
    int   edge_n = 0;
    logic m_active = 1'b0;
    logic m_abort  = 1'b0;
    int   m_start = 0, m_end = -1, m_w = 0, m_len = 0, m_rr = 0;
    logic [CNT_W-1:0] m_dplen = '0;
    logic [N_REQ-1:0] e_gnt, e_ack;
    logic [VW-1:0]    exp_v, act_v;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active = 1'b0;
                m_rr     = 0;
                m_dplen  = '0;
            end else if (!p_rst) begin
                edge_n++;
                if (m_active) begin
                    if (m_end >= 0 && edge_n == m_end + 1) begin
                        m_active = 1'b0;
                        m_rr     = (m_w + 1) % N_REQ;
                    end else if (m_end < 0 && edge_n >= m_start + 3) begin
                        if (p_done) begin
                            m_end = edge_n;
                        end else if (edge_n - (m_start + 3) == TO_MAIN - 1) begin
                            m_end   = edge_n;
                            m_abort = 1'b1;
                        end
                    end
                end else if (p_req != '0) begin
                    m_w = -1;
                    for (int k = 0; k < N_REQ; k++)
                        if (m_w < 0 && p_req[(m_rr + k) % N_REQ]) m_w = (m_rr + k) % N_REQ;
                    m_active = 1'b1;
                    m_start  = edge_n;
                    m_abort  = 1'b0;
                    m_len    = int'(p_len[m_w*CNT_W +: CNT_W]);
                    m_end    = (m_len == 0) ? edge_n + 1 : -1;
                end
                if (m_active && m_len != 0 && edge_n == m_start + 1) m_dplen = CNT_W'(m_len);
            end
            e_gnt = '0;
            e_ack = '0;
            if (m_active) e_gnt[m_w] = 1'b1;
            if (m_active && m_end >= 0 && edge_n == m_end) e_ack[m_w] = 1'b1;
            exp_v = {e_gnt, e_ack, (e_ack != '0) && m_abort, m_active,
                     m_active && m_len != 0 && edge_n == m_start + 1,
                     (e_ack != '0) && m_len != 0, m_dplen};
            act_v = {gnt, ack, err, busy, dp_load, dp_clr, dp_len};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_model edge %0d: got 0x%h expected 0x%h", edge_n, act_v, exp_v);
            end
            if (e_ack != '0)
                $display("job done: requester %0d len %0d abort %0d", m_w, m_len, m_abort);
            p_rst  = rst;
            p_req  = req;
            p_len  = len_flat;
            p_done = dp_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    int n;
    int ng, idle_run;
    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [N_REQ-1:0] prev_gnt;

    initial begin
        req        = '0;
        len_flat   = '0;
        req_to     = '0;
        len_to     = '0;
        dp_done_to = 1'b0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_len", 32'(dp_len), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dp_load", 32'(dp_load), 32'd0);
        rst = 1'b0;

        // T2: all requesters held with len 3 -> grants 0,1,2,3,0 with one idle cycle between
        dp_delay = 2;
        for (int i = 0; i < N_REQ; i++) set_len(i, 3);
        req = 4'b1111;
        ng = 0; idle_run = 0; prev_gnt = '0;
        for (int c = 0; c < 300 && ng < 5; c++) begin
            step();
            if (!busy) idle_run++;
            if (gnt != '0 && prev_gnt == '0) begin
                order[ng] = oh2idx(gnt);
                chk("t2_onehot", 32'($onehot(gnt)), 32'd1);
                if (ng > 0) chk("t2_gap", 32'(idle_run), 32'd1);
                ng++;
                idle_run = 0;
            end
            prev_gnt = gnt;
        end
        req = '0;
        chk("t2_count", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) chk("t2_order", 32'(order[i]), 32'(exp_order[i]));
        wait_idle(40);

        // T1: single job, len 5, datapath done 11 cycles after load
        dp_delay = 11;
        set_len(0, 5);
        req = 4'b0001;
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_no_load_yet", 32'(dp_load), 32'd0);
        step();
        chk("t1_load", 32'(dp_load), 32'd1);
        chk("t1_dp_len", 32'(dp_len), 32'd5);
        wait_ack(40, n);
        chk("t1_ack_latency", 32'(n), 32'd12);
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_clr", 32'(dp_clr), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        req = '0;
        step();
        chk("t1_gnt_clear", 32'(gnt), 32'd0);

        // T3: serve 2, then req=0101 must grant 0 (search 3 then 0)
        dp_delay = 3;
        set_len(2, 2);
        req = 4'b0100;
        wait_ack(30, n);
        chk("t3_first_ack", 32'(ack), 32'h4);
        req = '0;
        wait_idle(10);
        set_len(0, 1);
        req = 4'b0101;
        step();
        chk("t3_gnt", 32'(gnt), 32'h1);
        wait_ack(30, n);
        req = '0;
        wait_idle(10);

        // T4: zero length job never loads or clears the datapath
        set_len(1, 0);
        req = 4'b0010;
        step();
        chk("t4_gnt", 32'(gnt), 32'h2);
        chk("t4_no_load", 32'(dp_load), 32'd0);
        step();
        chk("t4_ack", 32'(ack), 32'h2);
        chk("t4_no_load2", 32'(dp_load), 32'd0);
        chk("t4_no_clr", 32'(dp_clr), 32'd0);
        req = '0;
        step();
        chk("t4_idle", 32'(busy), 32'd0);

        // T5b: main instance watchdog (64) with datapath never done
        dp_tie0 = 1'b1;
        set_len(3, 4);
        req = 4'b1000;
        step();
        step();
        chk("t5b_load", 32'(dp_load), 32'd1);
        wait_ack(80, n);
        chk("t5b_ack_latency", 32'(n), 32'(TO_MAIN + 1));
        chk("t5b_ack", 32'(ack), 32'h8);
        chk("t5b_err", 32'(err), 32'd1);
        chk("t5b_clr", 32'(dp_clr), 32'd1);
        req = '0;
        wait_idle(10);
        dp_tie0 = 1'b0;

        // T5: 8-cycle watchdog instance, dp_done tied low
        len_to[0*CNT_W +: CNT_W] = CNT_W'(3);
        req_to = 4'b0001;
        step();
        chk("t5_gnt", 32'(gnt_to), 32'h1);
        step();
        chk("t5_load", 32'(dp_load_to), 32'd1);
        chk("t5_dp_len", 32'(dp_len_to), 32'd3);
        step();
        chk("t5_busy_run", 32'(busy_to), 32'd1);
        n = 0;
        do begin
            step();
            n++;
        end while (ack_to == '0 && n < 20);
        chk("t5_ack_latency", 32'(n), 32'(TO_SHORT));
        chk("t5_ack", 32'(ack_to), 32'h1);
        chk("t5_err", 32'(err_to), 32'd1);
        chk("t5_clr", 32'(dp_clr_to), 32'd1);
        len_to[1*CNT_W +: CNT_W] = CNT_W'(2);
        req_to = 4'b0010;
        step();
        chk("t5_gap", 32'(gnt_to), 32'd0);
        step();
        chk("t5_next_gnt", 32'(gnt_to), 32'h2);
        n = 0;
        do begin
            step();
            n++;
        end while (ack_to == '0 && n < 30);
        chk("t5_next_ack", 32'(ack_to), 32'h2);
        req_to = '0;
        step();

        // T6: reset mid-RUN clears outputs asynchronously; pointer restarts at 0
        dp_delay = 30;
        set_len(2, 20);
        req = 4'b0100;
        step();
        step();
        step();
        chk("t6_gnt_run", 32'(gnt), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_gnt", 32'(gnt), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_ack", 32'(ack), 32'd0);
        chk("t6_async_dp_len", 32'(dp_len), 32'd0);
        req = '0;
        step();
        step();
        rst = 1'b0;
        dp_delay = 3;
        for (int i = 0; i < N_REQ; i++) set_len(i, 3);
        req = 4'b1111;
        step();
        chk("t6_first_gnt", 32'(gnt), 32'h1);
        req = 4'b0001;
        wait_ack(30, n);
        chk("t6_ack", 32'(ack), 32'h1);
        req = '0;
        wait_idle(10);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
